fetch_inst_queue: RTL

- Parametrised successor to the single-entry IF stage.
- Tracks up to DEPTH in-order instruction fetches, each either a memory request or an exception-tagged fetch with no memory access.
- Pairs in-order data_ok/rdata with request metadata, buffers completed fetches, and delivers them to ID through a valid/allowin handshake.
- On flush, drops all buffered state and silently discards the data_ok beats still owed by memory.

---
 rtl/fetch_inst_queue_pkg.sv | 11 +
 rtl/fetch_inst_queue_idx_fifo.sv | 35 +++
 rtl/fetch_inst_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_pkg.sv
// fetch_inst_queue_pkg: shared widths and ICACOP decode for the fetch queue.
package fetch_inst_queue_pkg;
    localparam int FETCH_META_WD = 40;
    localparam int FS_TO_DS_BUS_WD = FETCH_META_WD + 33;
    localparam logic [9:0] ICACOP_OP_HI = 10'b0000011000;
    localparam logic [2:0] ICACOP_OP_LO = 3'b000;

    function automatic logic is_icacop(input logic ex, input logic [31:0] inst);
        return !ex && inst[31:22] == ICACOP_OP_HI && inst[2:0] == ICACOP_OP_LO;
    endfunction
endpackage

// File: rtl/fetch_inst_queue_idx_fifo.sv
// fetch_idx_fifo: in-order FIFO of ring slot indices awaiting memory data.
module fetch_idx_fifo #(
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [IW-1:0] push_idx,
    input  logic          pop,
    output logic [IW-1:0] head_idx,
    output logic [IW:0]   count
);
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_ptr, rd_ptr;

    assign head_idx = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + IW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + IW'(1);
            count <= count + (IW+1)'(push) - (IW+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: DEPTH-entry in-order fetch ring pairing memory beats with
// fetch metadata, with flush-time discard accounting and a zero-latency bypass to ID.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int META_WD = FETCH_META_WD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fs_req_valid,
    input  logic                     fs_req_ex,
    input  logic [META_WD-1:0]       fs_req_meta,
    output logic                     fs_req_allowin,
    input  logic                     data_ok,
    input  logic [31:0]              inst_sram_rdata,
    input  logic                     flush,
    input  logic                     ds_allowin,
    output logic                     fs_to_ds_valid,
    output logic [META_WD+32:0]      fs_to_ds_bus,
    output logic                     discard_pending,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [META_WD-1:0] meta_q [DEPTH];
    logic [31:0]        inst_q [DEPTH];
    logic [DEPTH-1:0]   done_q, ex_q;
    logic [IW-1:0]      alloc_ptr, rd_ptr, fill_idx;
    logic [CW-1:0]      count, discard_cnt, idx_cnt, discard_next;
    logic               accept, discarding, beat_live, fill, head_fill, pop;
    logic [31:0]        head_inst;

    assign discarding     = discard_cnt != '0;
    assign fs_req_allowin = !reset && count < CW'(DEPTH)
                            && ({1'b0, idx_cnt} + {1'b0, discard_cnt}) < (CW+1)'(DEPTH);
    assign accept         = fs_req_valid && fs_req_allowin;
    assign beat_live      = data_ok && !discarding;
    assign fill           = beat_live && idx_cnt != '0;
    // A beat landing in the head slot is forwarded straight to ID.
    assign head_fill      = fill && fill_idx == rd_ptr;
    assign head_inst      = head_fill ? inst_sram_rdata : inst_q[rd_ptr];
    assign fs_to_ds_valid = count != '0 && !flush && (done_q[rd_ptr] || head_fill);
    assign pop            = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_bus   = {is_icacop(ex_q[rd_ptr], head_inst), head_inst, meta_q[rd_ptr]};
    assign discard_pending = discarding;
    assign occupancy      = count;

    // On flush every beat still owed (queued or issued this cycle) becomes a discard.
    always_comb begin
        discard_next = discard_cnt - CW'(data_ok && discarding);
        if (flush)
            discard_next = discard_next + idx_cnt - CW'(beat_live) + CW'(accept && !fs_req_ex);
    end

    fetch_idx_fifo #(.DEPTH(DEPTH)) u_idx_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (accept && !fs_req_ex && !flush),
        .push_idx (alloc_ptr),
        .pop      (fill && !flush),
        .head_idx (fill_idx),
        .count    (idx_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr   <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            discard_cnt <= '0;
            done_q      <= '0;
            ex_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush) begin
            alloc_ptr   <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            discard_cnt <= discard_next;
        end else begin
            if (accept) begin
                meta_q[alloc_ptr] <= fs_req_meta;
                done_q[alloc_ptr] <= fs_req_ex;
                ex_q[alloc_ptr]   <= fs_req_ex;
                alloc_ptr         <= alloc_ptr + IW'(1);
            end
            if (fill) begin
                inst_q[fill_idx] <= inst_sram_rdata;
                done_q[fill_idx] <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + IW'(1);
            count       <= count + CW'(accept) - CW'(pop);
            discard_cnt <= discard_next;
        end
    end

    a_no_orphan_beat: assert property (@(posedge clk) disable iff (reset)
        !(data_ok && !discarding && idx_cnt == '0));
endmodule
